// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Shares one uart_tx between a pixel stream and a status stream
//               and inserts a frame header (SYNC0, SYNC1, frame_count) after
//               every vsync rising edge. Optional macro UART_SCHED_CHECKSUM_EN
//               adds an XOR trailer of the pixel bytes ahead of each header
//               except the first one after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
  parameter logic [7:0] SYNC0       = 8'hA5,
  parameter logic [7:0] SYNC1       = 8'h5A,
  parameter int         PX_BURST    = 16,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic [7:0] px_data,
  input  logic       px_valid,
  output logic       px_ready,
  input  logic [7:0] st_data,
  input  logic       st_valid,
  output logic       st_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_busy,
  output logic [7:0] frame_count,
  output logic       frame_overrun,
  output logic       ack_error
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [1:0] c_SRC_PX   = 2'd0;
  localparam logic [1:0] c_SRC_ST   = 2'd1;
  localparam logic [1:0] c_SRC_HDR  = 2'd2;
  localparam logic [1:0] c_SRC_CSUM = 2'd3;
  localparam logic [7:0] c_PX_BURST = 8'(PX_BURST);
  localparam logic [7:0] c_ACK_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_vs_meta, r_vs_sync, r_vs_prev;
  logic       r_frame_pending;
  logic [7:0] r_frame_count;
  logic [1:0] r_hdr_idx;
  logic [7:0] r_burst_cnt;
  logic [7:0] r_ack_cnt;
  logic [1:0] r_src;
  logic [7:0] r_tx_data;
  logic       r_ack_error;
  logic       r_frame_overrun;
  logic       w_vs_edge;
  logic       w_sel;
  logic [1:0] w_sel_src;
  logic [7:0] w_sel_data;
  logic       w_byte_done;
  logic       w_timeout;
  logic       w_sync0_sel;

`ifdef UART_SCHED_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       r_csum_armed;
  logic       r_csum_sent;
`endif

  assign w_vs_edge     = r_vs_sync & ~r_vs_prev;
  assign w_sync0_sel   = w_sel && (w_sel_src == c_SRC_HDR) && (r_hdr_idx == 2'd0);
  assign tx_valid      = (r_state == S_ISSUE);
  assign px_ready      = (r_state == S_ISSUE) && (r_src == c_SRC_PX);
  assign st_ready      = (r_state == S_ISSUE) && (r_src == c_SRC_ST);
  assign tx_data       = r_tx_data;
  assign frame_count   = r_frame_count;
  assign frame_overrun = r_frame_overrun;
  assign ack_error     = r_ack_error;

  // Next-state and source selection; a header in progress always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_sel       = 1'b0;
    w_sel_src   = c_SRC_PX;
    w_sel_data  = px_data;
    w_byte_done = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!tx_busy) begin
          if ((r_hdr_idx != 2'd0) || r_frame_pending) begin
            w_sel     = 1'b1;
            w_sel_src = c_SRC_HDR;
            case (r_hdr_idx)
              2'd0:    w_sel_data = SYNC0;
              2'd1:    w_sel_data = SYNC1;
              default: w_sel_data = r_frame_count;
            endcase
`ifdef UART_SCHED_CHECKSUM_EN
            if ((r_hdr_idx == 2'd0) && r_csum_armed && !r_csum_sent) begin
              w_sel_src  = c_SRC_CSUM;
              w_sel_data = r_xor;
            end
`endif
          end else if (st_valid && (r_burst_cnt >= c_PX_BURST)) begin
            w_sel      = 1'b1;
            w_sel_src  = c_SRC_ST;
            w_sel_data = st_data;
          end else if (px_valid) begin
            w_sel      = 1'b1;
            w_sel_src  = c_SRC_PX;
            w_sel_data = px_data;
          end else if (st_valid) begin
            w_sel      = 1'b1;
            w_sel_src  = c_SRC_ST;
            w_sel_data = st_data;
          end
        end
        if (w_sel) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_ack_cnt == c_ACK_LAST) begin
          w_timeout   = 1'b1;
          w_byte_done = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        if (!tx_busy) begin
          w_byte_done = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Two-flop vsync synchroniser plus edge-detect history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_vs_meta <= vsync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  // Frame bookkeeping; an edge landing on the SYNC0 launch queues the next frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_pending <= 1'b0;
      r_frame_overrun <= 1'b0;
      r_frame_count   <= 8'h00;
    end else begin
      r_frame_overrun <= w_vs_edge && r_frame_pending && !w_sync0_sel;
      if (w_vs_edge)        r_frame_pending <= 1'b1;
      else if (w_sync0_sel) r_frame_pending <= 1'b0;
      if (w_sync0_sel)      r_frame_count   <= r_frame_count + 8'd1;
    end
  end

  // Byte launch datapath, burst fairness counter and header sequencing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_src       <= c_SRC_PX;
      r_tx_data   <= 8'h00;
      r_burst_cnt <= 8'h00;
      r_hdr_idx   <= 2'd0;
    end else begin
      if (w_sel) begin
        r_src     <= w_sel_src;
        r_tx_data <= w_sel_data;
        if (w_sel_src == c_SRC_PX) begin
          if (r_burst_cnt != 8'hFF) r_burst_cnt <= r_burst_cnt + 8'd1;
        end else if (w_sel_src == c_SRC_ST) begin
          r_burst_cnt <= 8'h00;
        end
      end
      if (w_byte_done && (r_src == c_SRC_HDR))
        r_hdr_idx <= (r_hdr_idx == 2'd2) ? 2'd0 : r_hdr_idx + 2'd1;
    end
  end

  // Acknowledge watchdog; a missed acknowledge is latched until reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_cnt   <= 8'h00;
      r_ack_error <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)                    r_ack_cnt <= 8'h00;
      else if (r_state == S_WAIT_ACK && !tx_busy) r_ack_cnt <= r_ack_cnt + 8'd1;
      if (w_timeout) r_ack_error <= 1'b1;
    end
  end

`ifdef UART_SCHED_CHECKSUM_EN
  // Running XOR of pixel bytes since the last header, emitted as a trailer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_xor        <= 8'h00;
      r_csum_armed <= 1'b0;
      r_csum_sent  <= 1'b0;
    end else if (w_sel) begin
      if (w_sel_src == c_SRC_PX) begin
        r_xor <= r_xor ^ w_sel_data;
      end else if (w_sel_src == c_SRC_CSUM) begin
        r_xor       <= 8'h00;
        r_csum_sent <= 1'b1;
      end else if (w_sync0_sel) begin
        r_xor        <= 8'h00;
        r_csum_armed <= 1'b1;
        r_csum_sent  <= 1'b0;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Directed bench for uart_tx_scheduler with a small uart_tx
//               model and a scoreboard of expected transmitted bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int BUSY_LEN = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       vsync;
  logic [7:0] px_data;
  logic       px_valid;
  logic       px_ready;
  logic [7:0] st_data;
  logic       st_valid;
  logic       st_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;
  logic [7:0] frame_count;
  logic       frame_overrun;
  logic       ack_error;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] px_q[$];
  logic [7:0] st_q[$];
  int model_mode = 0;   // 0 normal, 1 stuck busy, 2 never busy
  int busy_left;
  int px_ready_cnt = 0;
  int st_ready_cnt = 0;
  int overrun_cnt  = 0;

  uart_tx_scheduler dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .vsync        (vsync),
    .px_data      (px_data),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_busy      (tx_busy),
    .frame_count  (frame_count),
    .frame_overrun(frame_overrun),
    .ack_error    (ack_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // uart_tx model: busy rises the cycle after a data_valid and stays up BUSY_LEN cycles.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end else if (model_mode == 1) begin
      tx_busy <= 1'b1;
    end else if (model_mode == 2) begin
      tx_busy <= 1'b0;
    end else if (tx_valid && !tx_busy) begin
      tx_busy   <= 1'b1;
      busy_left <= BUSY_LEN;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_left <= 0;
      tx_busy   <= 1'b0;
    end
  end

  // Scoreboard compare on each launched byte, source queues and pulse counters.
  always @(negedge clock) begin
    if (reset_n) begin
      if (tx_valid) begin
        check("valid_while_busy", {31'd0, tx_busy}, 32'd0);
        check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      if (px_ready) begin
        px_ready_cnt++;
        if (px_q.size() != 0) void'(px_q.pop_front());
      end
      if (st_ready) begin
        st_ready_cnt++;
        if (st_q.size() != 0) void'(st_q.pop_front());
      end
      if (frame_overrun) overrun_cnt++;
    end
    px_valid = (px_q.size() != 0);
    px_data  = (px_q.size() != 0) ? px_q[0] : 8'h00;
    st_valid = (st_q.size() != 0);
    st_data  = (st_q.size() != 0) ? st_q[0] : 8'h00;
  end

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    px_q.delete();
    st_q.delete();
    exp_q.delete();
    model_mode = 0;
    repeat (2) @(negedge clock);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_frame_count", {24'd0, frame_count}, 32'd0);
    check("rst_ack_error", {31'd0, ack_error}, 32'd0);
    px_ready_cnt = 0;
    st_ready_cnt = 0;
    overrun_cnt  = 0;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, exp_q.size(), 32'd0);
    repeat (12) @(negedge clock);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, {31'd0, tx_valid}, 32'd1);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    repeat (6) @(negedge clock);
    vsync = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  initial begin
    int idle_viol;
    reset_n = 1'b0;
    vsync   = 1'b0;
    repeat (3) @(negedge clock);
    // Reset state while reset is held.
    check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset_px_ready", {31'd0, px_ready}, 32'd0);
    check("reset_st_ready", {31'd0, st_ready}, 32'd0);
    check("reset_tx_data", {24'd0, tx_data}, 32'd0);
    check("reset_frame_count", {24'd0, frame_count}, 32'd0);
    check("reset_overrun", {31'd0, frame_overrun}, 32'd0);
    check("reset_ack_error", {31'd0, ack_error}, 32'd0);
    reset_n = 1'b1;

    // Idle inputs: nothing happens for 100 cycles.
    idle_viol = 0;
    repeat (100) begin
      @(negedge clock);
      if (tx_valid || px_ready || st_ready || frame_count != 8'h00 || ack_error) idle_viol++;
    end
    check("idle_quiet", idle_viol, 32'd0);

    // Three pixel bytes in order.
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    px_q.push_back(8'h10);  px_q.push_back(8'h11);  px_q.push_back(8'h12);
    drain("px_drain", 300);
    check("px_ready_count", px_ready_cnt, 32'd3);

    // vsync rises while a pixel byte is on the wire: byte completes, header follows.
    exp_q.push_back(8'h20);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h01);
    px_q.push_back(8'h20);
    wait_valid("mid_px_launch", 50);
    vsync = 1'b1;
    drain("hdr_drain", 300);
    vsync = 1'b0;
    check("hdr_frame_count", {24'd0, frame_count}, 32'd1);
    check("hdr_no_overrun", overrun_cnt, 32'd0);

    // Burst arbitration: 16 pixels then one status, repeating.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + 16 * j + i));
      exp_q.push_back(8'(8'hC0 + j));
    end
    for (int i = 0; i < 48; i++) px_q.push_back(8'(8'h40 + i));
    for (int j = 0; j < 3; j++) st_q.push_back(8'(8'hC0 + j));
    drain("burst_drain", 2000);
    check("burst_px_count", px_ready_cnt, 32'd48);
    check("burst_st_count", st_ready_cnt, 32'd3);

    // Two vsync edges while uart is stuck busy: one overrun, one header.
    do_reset();
    model_mode = 1;
    repeat (3) @(negedge clock);
    vsync_pulse();
    vsync_pulse();
    check("overrun_count", overrun_cnt, 32'd1);
    check("overrun_no_start", {24'd0, frame_count}, 32'd0);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h01);
    model_mode = 0;
    drain("overrun_drain", 300);
    check("overrun_frame_count", {24'd0, frame_count}, 32'd1);
    check("overrun_single", overrun_cnt, 32'd1);

    // Acknowledge timeout: busy never rises.
    model_mode = 2;
    exp_q.push_back(8'h77);
    px_q.push_back(8'h77);
    wait_valid("ack_launch", 50);
    repeat (15) @(negedge clock);
    check("ack_err_before", {31'd0, ack_error}, 32'd0);
    @(negedge clock);
    check("ack_err_after", {31'd0, ack_error}, 32'd1);
    model_mode = 0;
    exp_q.push_back(8'h78);
    px_q.push_back(8'h78);
    drain("ack_recover_drain", 300);
    check("ack_err_sticky", {31'd0, ack_error}, 32'd1);

    // Two frames with pixels between; optional XOR trailer before the second header.
    do_reset();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h01);
    vsync_pulse();
    drain("frame1_drain", 300);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
    px_q.push_back(8'h01);  px_q.push_back(8'h02);  px_q.push_back(8'h04);
    drain("frame_px_drain", 300);
`ifdef UART_SCHED_CHECKSUM_EN
    exp_q.push_back(8'h07);
`endif
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h02);
    vsync_pulse();
    drain("frame2_drain", 300);
    check("frame2_count", {24'd0, frame_count}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
